// File: rtl/buffer_pkg.sv
// buffer_pkg: shared defaults, count-width helper and stage-state struct helper for buffer_pipe
`define BUF_STAGE_T(w) struct packed {logic v; logic [(w)-1:0] d;}
package buffer_pkg;
  localparam int BUF_DEF_WIDTH = 2;
  localparam int BUF_DEF_DEPTH = 4;
  localparam int BUF_DEF_ILLEGAL = 'b01;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/buffer_stage.sv
// buffer_stage: one valid/data register slice of the elastic delay line
module buffer_stage import buffer_pkg::*; #(
  parameter int WIDTH = BUF_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             up_v,
  input  logic [WIDTH-1:0] up_d,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  typedef `BUF_STAGE_T(WIDTH) stage_t;
  stage_t st_q, st_d;
  always_comb begin
    st_d.v = flush ? 1'b0 : (adv ? up_v : st_q.v);
    st_d.d = (adv && up_v) ? up_d : st_q.d;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st_q <= '0;
    else st_q <= st_d;
  assign v = st_q.v;
  assign d = st_q.d;
endmodule

// File: rtl/buffer_pipe.sv
// buffer_pipe: elastic DEPTH-stage valid/ready delay line with flush and occupancy count
// Optional BUFFER_PIPE_FILTER_EN scrubs ILLEGAL_CODE input words to zero.
module buffer_pipe import buffer_pkg::*; #(
  parameter int WIDTH = BUF_DEF_WIDTH,
  parameter int DEPTH = BUF_DEF_DEPTH
`ifdef BUFFER_PIPE_FILTER_EN
  , parameter logic [WIDTH-1:0] ILLEGAL_CODE = WIDTH'(BUF_DEF_ILLEGAL)
`endif
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [cnt_w(DEPTH)-1:0]  count
);
  localparam int CW = cnt_w(DEPTH);
  logic [DEPTH-1:0] v, up_v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [DEPTH:0] adv;
  logic [WIDTH-1:0] in_word;
  logic acc, emit;
  logic [CW-1:0] count_q, count_d;
  // a stage may advance when it is empty or everything downstream advances
  always_comb begin
    adv[DEPTH] = out_ready;
    for (int j = DEPTH - 1; j >= 0; j--) adv[j] = ~v[j] | adv[j+1];
  end
`ifdef BUFFER_PIPE_FILTER_EN
  assign in_word = (in_data == ILLEGAL_CODE) ? '0 : in_data;
`else
  assign in_word = in_data;
`endif
  assign in_ready = adv[0] & ~flush;
  assign acc = in_valid & in_ready;
  assign out_valid = v[DEPTH-1];
  assign emit = out_valid & out_ready;
  assign out_data = out_valid ? d[DEPTH-1] : '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    if (i == 0) begin : g_in
      assign up_v[i] = acc;
      assign up_d[i] = in_word;
    end else begin : g_mid
      assign up_v[i] = v[i-1];
      assign up_d[i] = d[i-1];
    end
    buffer_stage #(.WIDTH(WIDTH)) u_st (
      .clk(clk), .reset_n(reset_n), .flush(flush), .adv(adv[i]),
      .up_v(up_v[i]), .up_d(up_d[i]), .v(v[i]), .d(d[i])
    );
  end
  always_comb count_d = flush ? '0 : count_q + CW'(acc) - CW'(emit);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: tb/tb_buffer_pipe.sv
// tb_buffer_pipe: directed scoreboard bench for buffer_pipe (WIDTH=2, DEPTH=4)
module tb_buffer_pipe;
  logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [1:0] in_data = 0, out_data, e;
  logic [2:0] count;
  logic [1:0] q[$], seen[$];
  int total = 0, bad = 0, cyc = 0, first_acc = -1, first_ov = -1, max_cnt = 0;
  logic [1:0] w1[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] w2[6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1};
`ifdef BUFFER_PIPE_FILTER_EN
  logic [1:0] w6[3] = '{2'b00, 2'b10, 2'b11};
`else
  logic [1:0] w6[3] = '{2'b01, 2'b10, 2'b11};
`endif
  always #5 clk = ~clk;
  buffer_pipe dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [1:0] model(input logic [1:0] w);
`ifdef BUFFER_PIPE_FILTER_EN
    return (w == 2'b01) ? 2'b00 : w;
`else
    return w;
`endif
  endfunction
  // monitor: occupancy vs scoreboard, emitted words vs queue head, pushes on accept
  always @(negedge clk) begin
    cyc++;
    chk("count_vs_queue", int'(count), q.size());
    if (!out_valid) chk("idle_out_data", int'(out_data), 0);
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && out_ready) begin
      chk("out_pending", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_data", int'(out_data), int'(e));
      end
      seen.push_back(out_data);
    end
    if (in_valid && in_ready && reset_n) begin
      q.push_back(model(in_data));
      if (first_acc < 0) first_acc = cyc;
    end
    if (int'(count) > max_cnt) max_cnt = int'(count);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] w);
    bit ok;
    ok = 0;
    in_valid = 1;
    in_data = w;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 0;
    chk("send_accepted", int'(ok), 1);
  endtask
  task automatic drain();
    out_ready = 1;
    for (int k = 0; k < 100 && count != 0; k++) step();
    step();
    chk("drain_empty", int'(count), 0);
  endtask
  initial begin
    int acc_n;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    reset_n = 1;
    step();
    // streaming with consumer always ready
    first_acc = -1; first_ov = -1; max_cnt = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) send(w1[i]);
    drain();
    chk("t1_latency", first_ov - first_acc, 4);
    chk("t1_peak_count", max_cnt, 4);
    // stalled consumer, six offers
    out_ready = 0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_data = w2[i];
      @(negedge clk);
      if (in_ready) acc_n++;
      if (i >= 4) chk("t2_in_ready_full", int'(in_ready), 0);
      step();
      in_valid = 0;
    end
    chk("t2_accepted", acc_n, 4);
    chk("t2_count", int'(count), 4);
    out_ready = 1;
    send(w2[4]);
    send(w2[5]);
    drain();
    // spaced words collapse toward the output
    out_ready = 0;
    send(2'd3);
    step(); step();
    send(2'd2);
    step(); step();
    chk("t3_count", int'(count), 2);
    chk("t3_in_ready", int'(in_ready), 1);
    chk("t3_out_valid", int'(out_valid), 1);
    chk("t3_out_data", int'(out_data), 3);
    drain();
    // flush a full buffer
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(w1[i]);
    chk("t4_full_count", int'(count), 4);
    flush = 1;
    in_valid = 1;
    in_data = 2'd1;
    @(negedge clk);
    chk("t4_flush_in_ready", int'(in_ready), 0);
    step();
    flush = 0;
    in_valid = 0;
    q.delete();
    chk("t4_out_valid", int'(out_valid), 0);
    chk("t4_count", int'(count), 0);
    chk("t4_out_data", int'(out_data), 0);
    // asynchronous reset mid-transfer
    send(2'd1); send(2'd2); send(2'd3);
    #2;
    reset_n = 0;
    q.delete();
    #1;
    chk("t5_out_valid", int'(out_valid), 0);
    chk("t5_count", int'(count), 0);
    chk("t5_out_data", int'(out_data), 0);
    @(negedge clk);
    #2;
    reset_n = 1;
    step();
    first_acc = -1; first_ov = -1;
    out_ready = 1;
    send(2'd2); send(2'd3); send(2'd1);
    drain();
    chk("t5_latency", first_ov - first_acc, 4);
    // illegal-code scrubbing (or pass-through in the default build)
    seen.delete();
    out_ready = 1;
    send(2'b01); send(2'b10); send(2'b11);
    drain();
    chk("t6_seen_count", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++) chk("t6_word", int'(seen[i]), int'(w6[i]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach the summary");
    $fatal(1);
  end
endmodule
